// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_pkg
// Description : Shared AXI4-Lite response codes, command-master state
//               encoding and timer register map offsets.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RESP    = 3'd5
    } axil_mst_state_t;

    // Timer peripheral register map (byte offsets)
    localparam logic [7:0] TMR_CTRL     = 8'h00;
    localparam logic [7:0] TMR_STATUS   = 8'h04;
    localparam logic [7:0] TMR_LOAD     = 8'h08;
    localparam logic [7:0] TMR_VALUE    = 8'h0C;
    localparam logic [7:0] TMR_PRESCALE = 8'h10;
    localparam logic [7:0] TMR_COMPARE  = 8'h14;
    localparam logic [7:0] TMR_IRQ_EN   = 8'h18;
    localparam logic [7:0] TMR_IRQ_STAT = 8'h1C;

    // States in which the master is waiting on the slave
    function automatic logic is_wait_state(input axil_mst_state_t s);
        return (s == ST_WR) || (s == ST_WR_RESP) ||
               (s == ST_RD_ADDR) || (s == ST_RD_DATA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : axil_cmd_master
// Description : Converts a valid/ready command stream into single AXI4-Lite
//               read/write transactions and returns completions on a
//               valid/ready response stream. One transaction outstanding.
//               Optional hung-slave watchdog: AXIL_CMD_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    m_axi_aclk,
    input  logic                    m_axi_aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic                    busy
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    ,
    output logic                    timeout_flag
`endif
);

    localparam int c_strb_w = DATA_WIDTH / 8;

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("axil_cmd_master: only DATA_WIDTH=32 is supported");
        end
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("axil_cmd_master: TIMEOUT_CYCLES must be at least 2");
        end
    endgenerate

    axil_mst_state_t         r_state, w_state_nxt;
    logic                    r_cmd_ready, w_cmd_ready_nxt;
    logic                    r_busy, w_busy_nxt;
    logic                    r_awvalid, w_awvalid_nxt;
    logic                    r_wvalid, w_wvalid_nxt;
    logic                    r_bready, w_bready_nxt;
    logic                    r_arvalid, w_arvalid_nxt;
    logic                    r_rready, w_rready_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_nxt;
    logic [c_strb_w-1:0]     r_wstrb, w_wstrb_nxt;
    logic                    r_write, w_write_nxt;
    logic                    r_rsp_valid, w_rsp_valid_nxt;
    logic                    r_rsp_write, w_rsp_write_nxt;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
    logic [1:0]              r_rsp_resp, w_rsp_resp_nxt;
    logic                    w_aw_done, w_w_done;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    localparam logic [31:0]           c_wdog_limit   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] c_timeout_data = DATA_WIDTH'(32'hDEAD_BEEF);

    logic [31:0] r_wdog, w_wdog_nxt;
    logic        r_timeout_flag, w_timeout_flag_nxt;
    logic        w_wdog_hit;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_write_nxt     = r_write;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_write_nxt = r_rsp_write;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_resp_nxt  = r_rsp_resp;
        w_aw_done       = 1'b0;
        w_w_done        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_addr_nxt  = cmd_addr;
                    w_wdata_nxt = cmd_wdata;
                    w_wstrb_nxt = cmd_wstrb;
                    w_write_nxt = cmd_write;
                    if (cmd_write) begin
                        w_state_nxt   = ST_WR;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = ST_RD_ADDR;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            ST_WR: begin
                // A channel is done once its valid has already dropped or handshakes now
                w_aw_done = !r_awvalid || m_axi_awready;
                w_w_done  = !r_wvalid  || m_axi_wready;
                if (m_axi_awready) w_awvalid_nxt = 1'b0;
                if (m_axi_wready)  w_wvalid_nxt  = 1'b0;
                if (w_aw_done && w_w_done) begin
                    w_state_nxt  = ST_WR_RESP;
                    w_bready_nxt = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (m_axi_bvalid && r_bready) begin
                    w_bready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_write_nxt = r_write;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_resp_nxt  = m_axi_bresp;
                    w_state_nxt     = ST_RESP;
                end
            end
            ST_RD_ADDR: begin
                if (m_axi_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_axi_rvalid && r_rready) begin
                    w_rready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_write_nxt = r_write;
                    w_rsp_rdata_nxt = m_axi_rdata;
                    w_rsp_resp_nxt  = m_axi_rresp;
                    w_state_nxt     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        // Hung slave: abandon the transaction and report a synthetic DECERR
        w_wdog_hit = is_wait_state(r_state) && (r_wdog == c_wdog_limit);
        if (w_wdog_hit) begin
            w_awvalid_nxt   = 1'b0;
            w_wvalid_nxt    = 1'b0;
            w_bready_nxt    = 1'b0;
            w_arvalid_nxt   = 1'b0;
            w_rready_nxt    = 1'b0;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_write_nxt = r_write;
            w_rsp_rdata_nxt = c_timeout_data;
            w_rsp_resp_nxt  = RESP_DECERR;
            w_state_nxt     = ST_RESP;
        end
        w_timeout_flag_nxt = r_timeout_flag | w_wdog_hit;
        if (w_state_nxt != r_state) begin
            w_wdog_nxt = '0;
        end else if (is_wait_state(r_state)) begin
            w_wdog_nxt = r_wdog + 32'd1;
        end else begin
            w_wdog_nxt = r_wdog;
        end
`endif

        w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_write     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_write     <= w_write_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_write <= w_rsp_write_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_resp  <= w_rsp_resp_nxt;
        end
    end

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_wdog         <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            r_wdog         <= w_wdog_nxt;
            r_timeout_flag <= w_timeout_flag_nxt;
        end
    end

    assign timeout_flag = r_timeout_flag;
`endif

    // One address register serves both channels; only one is ever active
    assign m_axi_awaddr  = r_addr;
    assign m_axi_araddr  = r_addr;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;
    assign cmd_ready     = r_cmd_ready;
    assign busy          = r_busy;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_write     = r_rsp_write;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;

endmodule
`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_cmd_master
// Description : Directed self-checking bench for axil_cmd_master with a
//               small timer-style AXI4-Lite slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_cmd_master;
    import axil_pkg::*;

    localparam int c_tmo = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_write, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
    logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
    logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
    logic [31:0] m_axi_rdata = '0;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    logic        timeout_flag;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    axil_cmd_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (c_tmo)
    ) dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_write     (rsp_write),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .busy          (busy)
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        ,
        .timeout_flag  (timeout_flag)
`endif
    );

    // ---------------- slave model ----------------
    logic [31:0] slv_mem [8] = '{default: '0};
    int          aw_lat = 0, w_lat = 0, b_lat = 0;
    logic        ar_stall = 1'b0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic        aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] aw_addr_q = '0, w_data_q = '0, ar_addr_q = '0;
    logic [3:0]  w_strb_q = '0;
    logic        hs_aw = 1'b0, hs_w = 1'b0, hs_b = 1'b0, hs_ar = 1'b0, hs_r = 1'b0;
    int          n_aw = 0, n_w = 0, n_rsp = 0;

    function automatic logic [33:0] slv_read(input logic [31:0] a);
        if (a < 32'h20)  return {RESP_OKAY, slv_mem[a[4:2]]};
        if (a < 32'h100) return {RESP_SLVERR, 16'hBAD0, a[15:0]};
        return {RESP_DECERR, 16'hDEC0, a[15:0]};
    endfunction

    always @(posedge clk) begin
        hs_aw = m_axi_awvalid && m_axi_awready;
        hs_w  = m_axi_wvalid && m_axi_wready;
        hs_b  = m_axi_bvalid && m_axi_bready;
        hs_ar = m_axi_arvalid && m_axi_arready;
        hs_r  = m_axi_rvalid && m_axi_rready;
        if (hs_aw) begin n_aw++; aw_addr_q = m_axi_awaddr; end
        if (hs_w)  begin n_w++; w_data_q = m_axi_wdata; w_strb_q = m_axi_wstrb; end
        if (hs_ar) ar_addr_q = m_axi_araddr;
        if (rsp_valid && rsp_ready) n_rsp++;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
            m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
            aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end else begin
            if (hs_aw) begin
                m_axi_awready = 1'b0; aw_got = 1'b1; aw_cnt = 0;
            end else if (m_axi_awvalid && !m_axi_awready) begin
                if (aw_cnt >= aw_lat) m_axi_awready = 1'b1; else aw_cnt++;
            end
            if (hs_w) begin
                m_axi_wready = 1'b0; w_got = 1'b1; w_cnt = 0;
            end else if (m_axi_wvalid && !m_axi_wready) begin
                if (w_cnt >= w_lat) m_axi_wready = 1'b1; else w_cnt++;
            end
            if (hs_b) m_axi_bvalid = 1'b0;
            if (aw_got && w_got && !m_axi_bvalid) begin
                if (b_cnt >= b_lat) begin
                    if (aw_addr_q < 32'h20) begin
                        for (int i = 0; i < 4; i++)
                            if (w_strb_q[i]) slv_mem[aw_addr_q[4:2]][8*i +: 8] = w_data_q[8*i +: 8];
                        m_axi_bresp = RESP_OKAY;
                    end else begin
                        m_axi_bresp = (aw_addr_q < 32'h100) ? RESP_SLVERR : RESP_DECERR;
                    end
                    m_axi_bvalid = 1'b1; aw_got = 1'b0; w_got = 1'b0; b_cnt = 0;
                end else begin
                    b_cnt++;
                end
            end
            if (hs_r) m_axi_rvalid = 1'b0;
            if (hs_ar) begin
                m_axi_arready = 1'b0;
                m_axi_rvalid  = 1'b1;
                {m_axi_rresp, m_axi_rdata} = slv_read(ar_addr_q);
            end else if (m_axi_arvalid && !m_axi_arready && !ar_stall) begin
                m_axi_arready = 1'b1;
            end
        end
    end

    // ---------------- checking and driving ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input int hold, output logic w,
                           output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        if (!rsp_valid) chk({tag, "_rsp_timeout"}, 64'(rsp_valid), 64'(1));
        w = rsp_write; d = rsp_rdata; r = rsp_resp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(rsp_valid), 64'(1));
            chk({tag, "_hold_payload"}, 64'({rsp_write, rsp_resp, rsp_rdata}), 64'({w, r, d}));
            chk({tag, "_hold_cmd_ready"}, 64'(cmd_ready), 64'(0));
        end
        if (hold > 0) chk({tag, "_cmd_ready_at_ack"}, 64'(cmd_ready), 64'(0));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (hold > 0) begin
            chk({tag, "_valid_after_ack"}, 64'(rsp_valid), 64'(0));
            chk({tag, "_cmd_ready_after_ack"}, 64'(cmd_ready), 64'(1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic        w;
        logic [31:0] d;
        logic [1:0]  r;
        int          aw0, w0, r0, n, seen;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                m_axi_rready, rsp_valid}), 64'(0));
        chk("rst_addr_data", 64'({m_axi_awaddr, m_axi_wdata}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Same-cycle AW/W write, then read back
        aw0 = n_aw; w0 = n_w;
        send_cmd(1'b1, 32'(TMR_STATUS), 32'h0000_00FF, 4'hF);
        chk("t1_busy", 64'(busy), 64'(1));
        get_rsp("t1w", 0, w, d, r);
        chk("t1_aw_hs", 64'(n_aw - aw0), 64'(1));
        chk("t1_w_hs", 64'(n_w - w0), 64'(1));
        chk("t1_awaddr", 64'(aw_addr_q), 64'h04);
        chk("t1_wr_rsp", 64'({w, r, d}), 64'({1'b1, 2'b00, 32'h0}));
        send_cmd(1'b0, 32'(TMR_STATUS), 32'h0, 4'h0);
        get_rsp("t1r", 0, w, d, r);
        chk("t1_rd_rsp", 64'({w, r, d}), 64'({1'b0, 2'b00, 32'h0000_00FF}));

        // Partial strobe write merges bytes 0..1 only
        send_cmd(1'b1, 32'(TMR_LOAD), 32'hAABB_CCDD, 4'h3);
        get_rsp("t1s", 0, w, d, r);
        send_cmd(1'b0, 32'(TMR_LOAD), 32'h0, 4'h0);
        get_rsp("t1sr", 0, w, d, r);
        chk("t1_strb_rd", 64'(d), 64'h0000_CCDD);

        // W accepted three cycles before AW
        aw_lat = 3; w_lat = 0;
        aw0 = n_aw; w0 = n_w; r0 = n_rsp;
        send_cmd(1'b1, 32'(TMR_VALUE), 32'h1234_5678, 4'hF);
        n = 0;
        while (n_w == w0 && n < 20) begin @(negedge clk); n++; end
        chk("t2_wvalid_drop", 64'(m_axi_wvalid), 64'(0));
        chk("t2_awvalid_held", 64'(m_axi_awvalid), 64'(1));
        chk("t2_aw_not_yet", 64'(n_aw - aw0), 64'(0));
        get_rsp("t2", 0, w, d, r);
        chk("t2_resp", 64'({w, r}), 64'({1'b1, 2'b00}));
        repeat (5) @(negedge clk);
        chk("t2_one_rsp", 64'(n_rsp - r0), 64'(1));
        chk("t2_one_aw", 64'(n_aw - aw0), 64'(1));

        // AW accepted before W
        aw_lat = 0; w_lat = 2;
        send_cmd(1'b1, 32'(TMR_PRESCALE), 32'h0000_0A5A, 4'hF);
        get_rsp("t2b", 0, w, d, r);
        w_lat = 0;
        send_cmd(1'b0, 32'(TMR_PRESCALE), 32'h0, 4'h0);
        get_rsp("t2br", 0, w, d, r);
        chk("t2b_rd", 64'({r, d}), 64'({2'b00, 32'h0000_0A5A}));

        // Slave error responses pass through
        send_cmd(1'b0, 32'h40, 32'h0, 4'h0);
        get_rsp("t3", 0, w, d, r);
        chk("t3_slverr_rd", 64'({w, r, d}), 64'({1'b0, 2'b10, 32'hBAD0_0040}));
        send_cmd(1'b1, 32'h80, 32'h5555_5555, 4'hF);
        get_rsp("t3w", 0, w, d, r);
        chk("t3_slverr_wr", 64'({w, r, d}), 64'({1'b1, 2'b10, 32'h0}));
        send_cmd(1'b0, 32'h1000, 32'h0, 4'h0);
        get_rsp("t3d", 0, w, d, r);
        chk("t3_decerr_rd", 64'({r, d}), 64'({2'b11, 32'hDEC0_1000}));

        // Response back-pressure for 5 cycles
        send_cmd(1'b0, 32'(TMR_STATUS), 32'h0, 4'h0);
        get_rsp("t4", 5, w, d, r);
        chk("t4_payload", 64'({w, r, d}), 64'({1'b0, 2'b00, 32'h0000_00FF}));

        // Reset while waiting for B
        b_lat = 10; r0 = n_rsp;
        send_cmd(1'b1, 32'(TMR_COMPARE), 32'h0000_CAFE, 4'hF);
        n = 0;
        while (!m_axi_bready && n < 50) begin @(negedge clk); n++; end
        chk("t5_in_wr_resp", 64'(m_axi_bready), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("t5_valids_clear", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                     m_axi_rready, rsp_valid}), 64'(0));
        chk("t5_cmd_ready", 64'({cmd_ready, busy}), 64'({1'b1, 1'b0}));
        repeat (2) @(negedge clk);
        rst_n = 1'b1; b_lat = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("t5_no_rsp", 64'(seen + (n_rsp - r0)), 64'(0));
        chk("t5_idle_ready", 64'(cmd_ready), 64'(1));
        send_cmd(1'b0, 32'(TMR_COMPARE), 32'h0, 4'h0);
        get_rsp("t5r", 0, w, d, r);
        chk("t5_not_written", 64'({r, d}), 64'({2'b00, 32'h0}));

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        chk("t6_flag_clear", 64'(timeout_flag), 64'(0));
        ar_stall = 1'b1;
        send_cmd(1'b0, 32'(TMR_IRQ_EN), 32'h0, 4'h0);
        n = 0;
        while (m_axi_arvalid && n < 100) begin n++; @(negedge clk); end
        chk("t6_arvalid_cycles", 64'(n), 64'(c_tmo));
        get_rsp("t6", 0, w, d, r);
        chk("t6_resp", 64'({w, r, d}), 64'({1'b0, 2'b11, 32'hDEAD_BEEF}));
        chk("t6_flag_set", 64'(timeout_flag), 64'(1));
        ar_stall = 1'b0;
        send_cmd(1'b0, 32'(TMR_STATUS), 32'h0, 4'h0);
        get_rsp("t6r", 0, w, d, r);
        chk("t6_recover", 64'({r, d}), 64'({2'b00, 32'h0000_00FF}));
        chk("t6_flag_sticky", 64'(timeout_flag), 64'(1));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- AXI4-Lite initiator that converts a simple valid/ready command stream into single AXI4-Lite read or write transactions.
- Returns each completion on a valid/ready response stream.
- Drives peripheral slaves such as the timer and other register blocks from a test sequencer, boot ROM walker or debug bridge.
- One outstanding transaction at a time; no bursts.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr and AXI address buses
DATA_WIDTH, 32, width of data buses (32 only is supported; wstrb width is DATA_WIDTH/8)
TIMEOUT_CYCLES, 1024, watchdog limit in clock cycles (used only with the optional feature)

Ports:
m_axi_aclk  in  1  clock
m_axi_aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  target byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_write  out  1  echo of cmd_write
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  AXI BRESP/RRESP, or timeout code
m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready  AXI4-Lite master channels, standard widths and directions
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous and active-low:
  - FSM goes to IDLE.
  - All *valid, bready, rready and rsp_* outputs reset to 0.
  - cmd_ready resets to 1.
  - Address and data registers reset to 0.
- All outputs are registered. cmd_ready = 1 only in IDLE.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - On cmd_valid && cmd_ready, latch cmd_*.
  - Next state is WR (cmd_write=1) or RD_ADDR (cmd_write=0).
  - awvalid+wvalid, or arvalid, go high the cycle after acceptance.
- WR:
  - awvalid and wvalid are asserted together and tracked independently (aw_done, w_done).
  - Each valid drops the cycle after its own handshake.
  - Both handshakes may occur in the same cycle or in either order.
  - Once both are done, go to WR_RESP with bready=1.
- WR_RESP: on bvalid && bready, capture bresp, set rsp_rdata=0 and rsp_write=1, drop bready, go to RESP.
- RD_ADDR: hold arvalid until arready; then drop arvalid, assert rready, go to RD_DATA.
- RD_DATA: on rvalid && rready, capture rdata/rresp, drop rready, go to RESP.
- RESP:
  - rsp_valid = 1, with payload stable until rsp_ready.
  - On rsp_ready: rsp_valid drops, go to IDLE, cmd_ready returns to 1.
  - Back-to-back commands: minimum 1 idle cycle between a response handshake and the next command acceptance.
- Address, data and strobe outputs stay stable while their valid is high (AXI rule).
- No valid is deasserted before its handshake, except by reset or timeout.
- Slave error responses (SLVERR 2'b10, DECERR 2'b11) pass through unmodified.
- Reset asserted mid-transaction aborts immediately; no response is generated.

Optional Feature:
- Macro: AXIL_CMD_MASTER_TIMEOUT_EN.
- When defined:
  - A 32-bit counter clears on every state change and increments in WR, WR_RESP, RD_ADDR and RD_DATA.
  - When the count reaches TIMEOUT_CYCLES-1, all AXI valid/ready outputs drop and the FSM goes to RESP.
  - The response carries rsp_resp=2'b11 and rsp_rdata=32'hDEAD_BEEF.
  - Output timeout_flag (1 bit) goes high and stays sticky until reset.
  - This deliberately breaks the protocol and exists only for hung-slave recovery.
- When not defined: no counter, no timeout_flag port, and the block waits indefinitely.

Decomposition:
- Shared package axil_pkg holds:
  - AXI response localparams: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - State enum axil_mst_state_t.
  - Timer register offset constants (0x00 to 0x1C) for bench reuse.
- Single module; no sub-module is needed. The watchdog stays inline under the macro.

Test Plan:
1. Write cmd addr=0x04, wdata=0x0000_00FF, wstrb=4'hF into the timer slave -> one AW and one W handshake, then bresp=00 and rsp_valid with rsp_write=1, rsp_resp=00; a subsequent read of 0x04 returns rsp_rdata=0x0000_00FF.
2. Slave that asserts wready 3 cycles before awready -> wvalid drops after its handshake, awvalid is held; exactly one response, rsp_resp=00.
3. Read of unmapped 0x40 from a slave returning rresp=2'b10 -> rsp_resp=2'b10, rsp_rdata equals the slave data.
4. rsp_ready held low for 5 cycles -> rsp_valid and payload stable for all 5 cycles; cmd_ready stays 0 until the cycle after rsp_ready.
5. m_axi_aresetn pulsed low while in WR_RESP -> all valids and readies are 0 immediately, cmd_ready=1 after reset, no rsp_valid.
6. With AXIL_CMD_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, a slave that never asserts arready -> arvalid drops at cycle 16, rsp_resp=11, rsp_rdata=0xDEADBEEF, timeout_flag=1.
